// File: rtl/vga_if.sv
// Display-side bundle of the VGA timing generator: run enable in, DAC sync/blank,
// pixel coordinates and raster strobes out.
interface vga_if #(
   parameter int XW = 10,
   parameter int YW = 10
);
   logic          i_en;
   logic          o_clk;
   logic          o_hs;
   logic          o_vs;
   logic          o_sync;
   logic          o_blank;
   logic          o_active;
   logic [XW-1:0] o_x;
   logic [YW-1:0] o_y;
   logic          o_line_start;
   logic          o_frame_start;
   logic [7:0]    o_frame_cnt;

   modport master (
      input  i_en,
      output o_clk, o_hs, o_vs, o_sync, o_blank, o_active,
      output o_x, o_y, o_line_start, o_frame_start, o_frame_cnt
   );

   modport slave (
      output i_en,
      input  o_clk, o_hs, o_vs, o_sync, o_blank, o_active,
      input  o_x, o_y, o_line_start, o_frame_start, o_frame_cnt
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. A clock divider produces the pixel
// enable; h/v counters walk the raster and every output is registered from the
// counter values being loaded on the same edge, so outputs never lag the counters.
module vga_timing_gen #(
   parameter int H_ACTIVE      = 640,
   parameter int H_FP          = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BP          = 48,
   parameter int V_ACTIVE      = 480,
   parameter int V_FP          = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BP          = 33,
   parameter int HS_POL        = 0,
   parameter int VS_POL        = 0,
   parameter int CLK_DIV       = 2,
   parameter int SYNC_ON_GREEN = 0,
   parameter int XW            = 10,
   parameter int YW            = 10
) (
   input  logic   clk,
   input  logic   rst,
   vga_if.master  vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = $clog2(CLK_DIV);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] H_VIS    = XW'(H_ACTIVE);
   localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] V_VIS    = YW'(V_ACTIVE);
   localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ON    = (HS_POL != 0);
   localparam logic          VS_ON    = (VS_POL != 0);
   localparam logic          SOG      = (SYNC_ON_GREEN != 0);

   logic [DW-1:0] div;
   logic [DW-1:0] div_nxt;
   logic [XW-1:0] h;
   logic [XW-1:0] h_nxt;
   logic [YW-1:0] v;
   logic [YW-1:0] v_nxt;
   logic          pix_ce;
   logic          h_wrap;
   logic          v_wrap;
   logic          hs_act;
   logic          vs_act;
   logic          act_nxt;

   logic          clk_q;
   logic          hs_q;
   logic          vs_q;
   logic          sync_q;
   logic          blank_q;
   logic          active_q;
   logic          line_start_q;
   logic          frame_start_q;
   logic [7:0]    frame_cnt_q;

   // Next divider/counter values and the sync/visible decode of those values.
   always_comb begin
      pix_ce  = vga.i_en & (div == DIV_LAST);
      h_wrap  = pix_ce & (h == H_LAST);
      v_wrap  = h_wrap & (v == V_LAST);
      div_nxt = div;
      h_nxt   = h;
      v_nxt   = v;
      if (vga.i_en) begin
         div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
      end
      if (h_wrap) begin
         h_nxt = '0;
      end else if (pix_ce) begin
         h_nxt = h + XW'(1);
      end
      if (v_wrap) begin
         v_nxt = '0;
      end else if (h_wrap) begin
         v_nxt = v + YW'(1);
      end
      hs_act  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
      vs_act  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
      act_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
   end

   // Timing state and registered outputs; everything holds while i_en is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div           <= '0;
         h             <= '0;
         v             <= '0;
         clk_q         <= 1'b0;
         hs_q          <= ~HS_ON;
         vs_q          <= ~VS_ON;
         sync_q        <= 1'b0;
         blank_q       <= 1'b1;
         active_q      <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
         if (vga.i_en) begin
            div      <= div_nxt;
            h        <= h_nxt;
            v        <= v_nxt;
            clk_q    <= (div_nxt >= DIV_HALF);
            hs_q     <= hs_act ? HS_ON : ~HS_ON;
            vs_q     <= vs_act ? VS_ON : ~VS_ON;
            sync_q   <= SOG ? ~(hs_act | vs_act) : 1'b0;
            blank_q  <= act_nxt;
            active_q <= act_nxt;
         end
         if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
      end
   end

   assign vga.o_clk         = clk_q;
   assign vga.o_hs          = hs_q;
   assign vga.o_vs          = vs_q;
   assign vga.o_sync        = sync_q;
   assign vga.o_blank       = blank_q;
   assign vga.o_active      = active_q;
   assign vga.o_x           = h;
   assign vga.o_y           = v;
   assign vga.o_line_start  = line_start_q;
   assign vga.o_frame_start = frame_start_q;
   assign vga.o_frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a small raster. The reference model
// derives every output from the count of enabled clocks since reset.
module tb_vga_timing_gen;
   localparam int HA = 4, HF = 1, HSY = 1, HB = 1;
   localparam int VA = 3, VF = 1, VSY = 1, VB = 1;
   localparam int CD = 3, HP = 1, VP = 1, SOG = 1;
   localparam int XW = 10, YW = 10;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;

   typedef struct packed {
      logic ck, hs, vs, sy, bl, ac;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic ls, fs;
      logic [7:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vga_if #(.XW(XW), .YW(YW)) bus ();

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(HP), .VS_POL(VP), .CLK_DIV(CD), .SYNC_ON_GREEN(SOG),
      .XW(XW), .YW(YW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vga (bus)
   );

   exp_t q[$];
   exp_t held;
   int   e_cnt    = 0;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic wrap_seen = 1'b0;

   function automatic exp_t reset_val();
      exp_t r;
      r    = '0;
      r.hs = (HP == 0);
      r.vs = (VP == 0);
      r.bl = 1'b1;
      r.ac = 1'b1;
      return r;
   endfunction

   // Raster position is pure arithmetic on the enabled-clock count e.
   function automatic exp_t model(int e);
      exp_t r;
      int d, p, h, v;
      logic hs, vs;
      d    = e % CD;
      p    = e / CD;
      h    = p % HT;
      v    = (p / HT) % VT;
      hs   = (h >= HA + HF) && (h < HA + HF + HSY);
      vs   = (v >= VA + VF) && (v < VA + VF + VSY);
      r.ck = (d >= CD / 2);
      r.hs = hs ? (HP != 0) : (HP == 0);
      r.vs = vs ? (VP != 0) : (VP == 0);
      r.sy = (SOG != 0) ? !(hs || vs) : 1'b0;
      r.ac = (h < HA) && (v < VA);
      r.bl = r.ac;
      r.x  = XW'(h);
      r.y  = YW'(v);
      r.ls = (d == 0) && (h == 0);
      r.fs = r.ls && (v == 0);
      r.fc = 8'((p / (HT * VT)) % 256);
      return r;
   endfunction

   function automatic exp_t dut_val();
      exp_t r;
      r.ck = bus.o_clk;         r.hs = bus.o_hs;       r.vs = bus.o_vs;
      r.sy = bus.o_sync;        r.bl = bus.o_blank;    r.ac = bus.o_active;
      r.x  = bus.o_x;           r.y  = bus.o_y;        r.ls = bus.o_line_start;
      r.fs = bus.o_frame_start; r.fc = bus.o_frame_cnt;
      return r;
   endfunction

   // One clock of stimulus; the response expected after the next rising edge is queued.
   task automatic step(input logic en, input logic rs);
      @(negedge clk);
      rst      = rs;
      bus.i_en = en;
      if (!rs) begin
         e_cnt = 0;
         held  = reset_val();
         q.push_back(held);
      end else if (en) begin
         e_cnt++;
         held = model(e_cnt);
         q.push_back(held);
         held.ls = 1'b0;
         held.fs = 1'b0;
      end else begin
         q.push_back(held);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation after each edge.
   initial begin : monitor
      exp_t exp_v, got;
      logic [7:0] prev_fc;
      prev_fc = 8'd0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (q.size() > 0) begin
            exp_v = q.pop_front();
            got   = dut_val();
            checks++;
            if (got !== exp_v) begin
               failures++;
               $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, got, exp_v);
            end
            if (got.fs) begin
               if (got.fc == 8'd0 && prev_fc == 8'd255) wrap_seen = 1'b1;
               prev_fc = got.fc;
            end
         end
      end
   end

   initial begin : driver
      exp_t got;
      int guard;
      logic found;
      bus.i_en = 1'b0;
      held     = reset_val();
      repeat (3) step(1'b0, 1'b0);
      repeat (300) step($urandom_range(0, 3) != 0, 1'b1);

      // Freeze for 50 clocks in the middle of hsync.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(1'b1, 1'b1);
         if (held.x == XW'(HA + HF) && (e_cnt % CD) == 1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL hsync_reach actual=0 required=1");
      end
      repeat (50) step(1'b0, 1'b1);

      // Run past 256 frames so the frame counter wraps.
      guard = 0;
      while ((e_cnt / CD) < 257 * HT * VT && guard < 60000) begin
         step($urandom_range(0, 3) != 0, 1'b1);
         guard++;
      end
      checks++;
      if (guard >= 60000) begin
         failures++;
         $display("FAIL frame_run actual=%0d required=%0d", e_cnt / CD, 257 * HT * VT);
      end

      // Asynchronous reset inside hsync must take effect before the next edge.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(1'b1, 1'b1);
         if (held.x == XW'(HA + HF)) found = 1'b1;
      end
      step(1'b1, 1'b0);
      #1;
      got = dut_val();
      checks++;
      if (!found || got !== reset_val()) begin
         failures++;
         $display("FAIL async_reset actual=%h required=%h", got, reset_val());
      end
      step(1'b1, 1'b0);
      repeat (200) step($urandom_range(0, 3) != 0, 1'b1);

      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain actual=%0d required=0", q.size());
      end
      checks++;
      if (!wrap_seen) begin
         failures++;
         $display("FAIL frame_cnt_wrap actual=0 required=1");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
